// File: rtl/dmem_responder_if.sv
// Request/response channel between the datapath load/store unit and the
// data-memory responder: valid/ready request plus valid/ready response.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data memory with a fixed number of wait states per access;
// flags misaligned and out-of-range accesses instead of touching storage.
//
// state | meaning
// IDLE  | ready for a request (once out of reset)
// WAIT  | request captured, counting down wait states
// RESP  | access done, response held until consumed
module dmem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input logic           clk,
    input logic           reset,
    dmem_responder_if.slave bus
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY > 0 ? LATENCY - 1 : 0);
    localparam logic [29:0] DEPTH_W  = 30'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        live_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        accept;
    logic        exec;

    logic [31:0] mem [DEPTH];

    // With zero wait states the access executes on the accept edge itself,
    // so it must see the live request rather than the captured copy.
    logic          in_idle;
    logic          acc_we;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic [3:0]    acc_be;
    logic          acc_err;
    logic [AW-1:0] acc_idx;

    assign in_idle   = (state_q == IDLE);
    assign acc_we    = in_idle ? bus.req_we    : we_q;
    assign acc_addr  = in_idle ? bus.req_addr  : addr_q;
    assign acc_wdata = in_idle ? bus.req_wdata : wdata_q;
    assign acc_be    = in_idle ? bus.req_be    : be_q;
    assign acc_err   = (acc_addr[1:0] != 2'b00) || (acc_addr[31:2] >= DEPTH_W);
    assign acc_idx   = acc_addr[AW+1:2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        exec    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid && live_q) begin
                    accept = 1'b1;
                    if (LATENCY == 0) begin
                        state_d = RESP;
                        exec    = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    exec    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (bus.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            live_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            live_q  <= 1'b1;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= bus.req_we;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                be_q    <= bus.req_be;
            end
            if (exec) begin
                err_q   <= acc_err;
                rdata_q <= (!acc_err && !acc_we) ? mem[acc_idx] : '0;
            end
        end
    end

    // Storage is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (exec && !acc_err && acc_we) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
        end
    end

    assign bus.req_ready  = in_idle && live_q;
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 and a LATENCY=0 instance driven
// against a word-array reference model with directed and random accesses.
module tb_dmem_responder;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_responder_if b2();
    dmem_responder_if b0();

    dmem_responder #(.DEPTH(64), .LATENCY(2)) dut2 (.clk(clk), .reset(reset), .bus(b2));
    dmem_responder #(.DEPTH(64), .LATENCY(0)) dut0 (.clk(clk), .reset(reset), .bus(b0));

    int total = 0;
    int bad   = 0;
    logic [31:0] mm [2][64];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic g_ready(input bit s);
        return s ? b0.req_ready : b2.req_ready;
    endfunction
    function automatic logic g_valid(input bit s);
        return s ? b0.resp_valid : b2.resp_valid;
    endfunction
    function automatic logic g_err(input bit s);
        return s ? b0.resp_err : b2.resp_err;
    endfunction
    function automatic logic [31:0] g_rdata(input bit s);
        return s ? b0.resp_rdata : b2.resp_rdata;
    endfunction

    task automatic drive(input bit s, input logic v, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be, input logic rr);
        if (s) begin
            b0.req_valid = v; b0.req_we = we; b0.req_addr = a;
            b0.req_wdata = d; b0.req_be = be; b0.resp_ready = rr;
        end else begin
            b2.req_valid = v; b2.req_we = we; b2.req_addr = a;
            b2.req_wdata = d; b2.req_be = be; b2.resp_ready = rr;
        end
    endtask

    task automatic set_rr(input bit s, input logic rr);
        if (s) b0.resp_ready = rr;
        else   b2.resp_ready = rr;
    endtask

    // Full transaction: model update, issue, latency/response checks, optional
    // backpressure for `hold` cycles, then return to idle.
    task automatic xact(input bit s, input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input int hold, output logic [31:0] rd_o);
        int lat_exp;
        int n;
        int idx;
        logic ok;
        logic exp_err;
        logic [31:0] exp_rd;
        lat_exp = s ? 0 : 2;
        exp_err = (a[1:0] != 2'b00) || (a[31:2] >= 30'd64);
        exp_rd  = 32'h0;
        idx     = int'(a[7:2]);
        if (!exp_err) begin
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) mm[s][idx][8*b +: 8] = d[8*b +: 8];
            end else begin
                exp_rd = mm[s][idx];
            end
        end
        n = 0;
        while (!g_ready(s) && n < 40) begin
            @(posedge clk); #1; n++;
        end
        chk("req_ready_before", {31'b0, g_ready(s)}, 32'd1);
        drive(s, 1'b1, we, a, d, be, hold == 0);
        @(posedge clk); #1;
        drive(s, 1'b0, 1'($urandom), $urandom, $urandom, 4'($urandom), hold == 0);
        n  = 0;
        ok = 1'b1;
        while (!g_valid(s) && n < 40) begin
            if (g_ready(s)) ok = 1'b0;
            @(posedge clk); #1; n++;
        end
        chk("latency", 32'(n), 32'(lat_exp));
        chk("no_ready_in_wait", {31'b0, ok}, 32'd1);
        chk("resp_err", {31'b0, g_err(s)}, {31'b0, exp_err});
        chk("resp_rdata", g_rdata(s), exp_rd);
        chk("no_ready_in_resp", {31'b0, g_ready(s)}, 32'd0);
        rd_o = g_rdata(s);
        if (hold > 0) begin
            ok = 1'b1;
            repeat (hold) begin
                @(posedge clk); #1;
                if (!g_valid(s) || g_rdata(s) !== rd_o || g_err(s) !== exp_err || g_ready(s))
                    ok = 1'b0;
            end
            chk("hold_stable", {31'b0, ok}, 32'd1);
            set_rr(s, 1'b1);
        end
        @(posedge clk); #1;
        chk("back_to_idle", {30'b0, g_valid(s), g_ready(s)}, 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        int n;
        int r;
        reset = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);

        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_req_ready", {31'b0, b2.req_ready}, 32'd0);
            chk("rst_resp_valid", {31'b0, b2.resp_valid}, 32'd0);
            chk("rst_rdata", b2.resp_rdata, 32'h0);
            chk("rst_err", {31'b0, b2.resp_err}, 32'd0);
        end
        reset = 1'b1;
        #1 chk("ready_before_edge", {31'b0, b2.req_ready}, 32'd0);
        @(posedge clk); #1;
        chk("ready_after_release", {31'b0, b2.req_ready}, 32'd1);
        chk("ready_after_release0", {31'b0, b0.req_ready}, 32'd1);

        for (int i = 0; i < 64; i++) begin
            xact(0, 1'b1, 32'(i * 4), $urandom, 4'hF, 0, rd);
            xact(1, 1'b1, 32'(i * 4), $urandom, 4'hF, 0, rd);
        end

        xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd);
        xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd);
        chk("load_deadbeef", rd, 32'hDEADBEEF);
        xact(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, 0, rd);
        xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd);
        chk("byte_enable_merge", rd, 32'hDE22BE44);

        xact(0, 1'b0, 32'h13, 32'h0, 4'h0, 0, rd);
        xact(0, 1'b1, 32'h100, 32'h55AA55AA, 4'hF, 0, rd);
        xact(0, 1'b0, 32'hFC, 32'h0, 4'h0, 0, rd);

        xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 5, rd);
        chk("backpressure_data", rd, 32'hDE22BE44);

        xact(1, 1'b1, 32'h8, 32'hA5A5_0F0F, 4'hF, 0, rd);
        xact(1, 1'b0, 32'h8, 32'h0, 4'h0, 3, rd);
        chk("lat0_load", rd, 32'hA5A5_0F0F);

        // Store abandoned while waiting: storage must keep its old value.
        xact(0, 1'b1, 32'h20, 32'h0, 4'hF, 0, rd);
        drive(0, 1'b1, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 1'b1);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        @(posedge clk); #1;
        reset = 1'b0;
        #1 chk("rst_wait_valid", {31'b0, b2.resp_valid}, 32'd0);
        @(posedge clk); #1;
        chk("rst_wait_valid_edge", {31'b0, b2.resp_valid}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_wait_ready", {31'b0, b2.req_ready}, 32'd1);
        xact(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, rd);
        chk("abandoned_store", rd, 32'h0);

        // Store interrupted while responding has already written.
        mm[0][9] = 32'h1234_5678;
        drive(0, 1'b1, 1'b1, 32'h24, 32'h1234_5678, 4'hF, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        n = 0;
        while (!b2.resp_valid && n < 40) begin
            @(posedge clk); #1; n++;
        end
        chk("rst_resp_latency", 32'(n), 32'd2);
        reset = 1'b0;
        #1 chk("rst_resp_valid_drop", {31'b0, b2.resp_valid}, 32'd0);
        set_rr(0, 1'b1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        xact(0, 1'b0, 32'h24, 32'h0, 4'h0, 0, rd);

        for (int k = 0; k < 240; k++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0)      a = $urandom;
            else if (r == 1) a = {24'h0, 6'($urandom), 2'($urandom_range(1, 3))};
            else             a = {24'h0, 6'($urandom), 2'b00};
            xact(bit'(k % 2), 1'($urandom), a, $urandom, 4'($urandom),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the processor's data-memory port. The datapath issues a load or store through this block.
- Serves word-organised storage behind a valid/ready request channel and a valid/ready response channel.
- Inserts a parameterised number of wait states, so pipelined cores and benches can exercise stall paths against a non-ideal memory.
- Flags misaligned and out-of-range accesses.

Parameters:
- DEPTH, 64, number of 32-bit words of storage (power of two, >=4).
- LATENCY, 2, wait cycles between request acceptance and response (0..15).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous active-low reset (asserted when 0, released synchronously to clk by the system).
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_be  input  4  store byte enables; bit i covers wdata[8i+7:8i].
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts response.
- resp_rdata  output  32  load data; 0 for stores and errors.
- resp_err  output  1  access was misaligned or out of range.

Behaviour:
- FSM states: IDLE, WAIT, RESP. Reset (reset=0) forces IDLE, clears the wait counter and all captured request fields, and sets resp_rdata=0, resp_err=0, resp_valid=0.
- req_ready is 0 while reset=0. Storage contents are not affected by reset.
- req_ready = (state==IDLE). resp_valid = (state==RESP). Both are registered-state decodes with no combinational path from inputs.
- Accept: req_valid & req_ready at a rising edge. The block captures we, addr, wdata and be.
  - LATENCY=0: next state RESP.
  - Otherwise: next state WAIT, with counter loaded to LATENCY-1.
- WAIT: counter decrements each cycle. When counter==0, the next state is RESP and the access executes on that edge.
- Access execution (the edge entering RESP):
  - error = (addr[1:0]!=0) | (addr[31:2] >= DEPTH).
  - Error: no storage write; resp_rdata=0; resp_err=1.
  - Store without error: write bytes whose be bit is 1; other bytes unchanged; resp_rdata=0; resp_err=0.
  - Load without error: resp_rdata = word at addr[31:2]; resp_err=0; be ignored.
- Latency: a request accepted at edge E0 produces resp_valid=1 in the cycle after edge E0+LATENCY.
- RESP: resp_valid, resp_rdata and resp_err hold stable until resp_valid & resp_ready at an edge, then the next state is IDLE.
  - No new request is accepted in the same edge (req_ready=0 in RESP).
  - Minimum spacing between accepts is LATENCY+2 cycles.
- Inputs on the request channel are ignored outside accept edges. Changes to req_* while in WAIT/RESP have no effect.
- Reset asserted mid-WAIT or mid-RESP: the transaction is abandoned immediately and resp_valid drops asynchronously.
  - A store in WAIT has not yet written storage, so it is lost.
  - A store in RESP has already written.
- Read-after-write: a load accepted after a store's response completes returns the new data. There is no overlap, so no hazard logic is needed.
- resp_ready held 1 permanently is legal; the response then lasts exactly one cycle.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles -> req_ready=0, resp_valid=0, resp_rdata=0. After release, req_ready=1 next cycle.
- Store then load, LATENCY=2, resp_ready=1:
  - Store addr 0x10, wdata 0xDEADBEEF, be 4'hF, accepted edge E0 -> resp_valid=1 in cycle after E0+2, resp_err=0, resp_rdata=0.
  - Then load 0x10 -> resp_rdata=0xDEADBEEF.
- Byte enables: storage word 0x10 = 0xDEADBEEF; store wdata 0x11223344 with be 4'b0101 -> subsequent load of 0x10 returns 0xDE22BE44.
- Errors:
  - Load addr 0x13 -> resp_err=1, resp_rdata=0.
  - Store addr 0x100 (DEPTH=64) -> resp_err=1, storage unchanged (a reload of 0x0FC is unchanged).
- Backpressure: resp_ready=0 for 5 cycles during RESP -> resp_valid, resp_rdata and resp_err stable throughout; req_ready=0. resp_ready=1 -> IDLE next cycle, req_ready=1.
- Reset mid-WAIT: store 0xCAFEF00D to 0x20 (prior value 0), pulse reset low one cycle after accept -> resp_valid stays 0. A load of 0x20 after release returns 0.
- LATENCY=0 build: accept at E0 -> resp_valid=1 in the cycle immediately after E0.
